// File: rtl/msk_rnd_prng.sv
// Seedable 64-bit Fibonacci LFSR that feeds fresh random bits to masked gadgets.
// After every seed load a fixed number of stepping cycles is discarded before output.
module msk_rnd_prng #(
  parameter int unsigned d        = 2,
  parameter int unsigned N_RND    = 1,
  parameter int unsigned N_WARMUP = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      seed,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             en,
  output logic [N_RND-1:0] rnd,
  output logic             rnd_valid
);

  typedef enum logic [1:0] {StUnseeded, StWarmup, StRun} state_e;

  localparam logic [9:0] WarmupLast = 10'(N_WARMUP - 1);

  // Share count is informational; keep it referenced so it is not flagged as unused.
  logic unused_d;
  assign unused_d = ^d;

  state_e             state_q, state_d;
  logic [63:0]        s_q, s_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [N_RND-1:0]   rnd_q, rnd_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [63:0]        s_step;
  logic [N_RND-1:0]   step_bits;
  logic               seed_fire;

  assign seed_ready = ~rst;
  assign seed_fire  = seed_valid & seed_ready;
  assign rnd        = rnd_q;
  assign rnd_valid  = rnd_valid_q;

  // N_RND chained LFSR steps; bit i is the feedback of step i.
  always_comb begin
    s_step    = s_q;
    step_bits = '0;
    for (int i = 0; i < N_RND; i++) begin
      step_bits[i] = s_step[63] ^ s_step[62] ^ s_step[60] ^ s_step[59];
      s_step       = {s_step[62:0], step_bits[i]};
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    if (seed_fire) begin
      // A new seed overrides any step in the same cycle.
      state_d = StWarmup;
      s_d     = (seed == 64'h0) ? 64'h1 : seed;
      cnt_d   = '0;
      rnd_d   = '0;
    end else begin
      unique case (state_q)
        StUnseeded: ;
        StWarmup: begin
          s_d   = s_step;
          cnt_d = cnt_q + 10'd1;
          if (cnt_q == WarmupLast) state_d = StRun;
        end
        StRun: begin
          if (en) begin
            s_d         = s_step;
            rnd_d       = step_bits;
            rnd_valid_d = 1'b1;
          end
        end
        default: state_d = StUnseeded;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StUnseeded;
      s_q         <= 64'h1;
      cnt_q       <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

endmodule

// File: tb/tb_msk_rnd_prng.sv
// Directed bench for msk_rnd_prng: one narrow/short-warm-up instance and one
// byte-wide instance with the default warm-up.
module tb_msk_rnd_prng;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seed1, seed8;
  logic        sv1, sv8, en1, en8;
  logic        sr1, sr8;
  logic [0:0]  rnd1;
  logic [7:0]  rnd8;
  logic        rv1, rv8;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] m_s;

  always #5 clk = ~clk;

  msk_rnd_prng #(.d(2), .N_RND(1), .N_WARMUP(1)) u_dut1 (
    .clk(clk), .rst(rst), .seed(seed1), .seed_valid(sv1), .seed_ready(sr1),
    .en(en1), .rnd(rnd1), .rnd_valid(rv1)
  );

  msk_rnd_prng #(.d(2), .N_RND(8), .N_WARMUP(64)) u_dut8 (
    .clk(clk), .rst(rst), .seed(seed8), .seed_valid(sv8), .seed_ready(sr8),
    .en(en8), .rnd(rnd8), .rnd_valid(rv8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: f = s63^s62^s60^s59, shifted in at bit 0.
  task automatic model_bits(input int n, output logic [63:0] bits);
    logic f;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      f       = m_s[63] ^ m_s[62] ^ m_s[60] ^ m_s[59];
      bits[i] = f;
      m_s     = {m_s[62:0], f};
    end
  endtask

  // 64 valid cycles of u_dut1 seeded with 1 (or 0), warm-up of one step already done.
  task automatic seq1(input string tag);
    logic [63:0] b;
    logic [63:0] exp;
    m_s = 64'h1;
    model_bits(1, b);
    for (int j = 1; j <= 64; j++) begin
      tick();
      model_bits(1, b);
      // Single 1 walks up from bit 0; first feedback hit is at bit 59.
      exp = (j < 59) ? 64'h0 : ((j == 59) ? 64'h1 : b);
      check({tag, "_rv"}, {63'h0, rv1}, 64'h1);
      check({tag, "_rnd"}, {63'h0, rnd1}, exp);
    end
  endtask

  initial begin
    logic [63:0] b1, b2, bw;
    int          n;
    rst = 1'b1; seed1 = '0; seed8 = '0; sv1 = 1'b0; sv8 = 1'b0; en1 = 1'b1; en8 = 1'b0;
    #12;
    check("rst_rnd1", {63'h0, rnd1}, 64'h0);
    check("rst_rv1", {63'h0, rv1}, 64'h0);
    check("rst_sr1", {63'h0, sr1}, 64'h0);
    check("rst_rnd8", {56'h0, rnd8}, 64'h0);
    check("rst_rv8", {63'h0, rv8}, 64'h0);

    @(negedge clk) rst = 1'b0;
    #1;
    check("sr1_run", {63'h0, sr1}, 64'h1);
    check("sr8_run", {63'h0, sr8}, 64'h1);

    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_out", {46'h0, rnd8, rnd1, rv8, rv1}, 64'h0);
    end

    // Seed 1 into the one-bit instance.
    seed1 = 64'h1; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    check("s1_e0_rv", {63'h0, rv1}, 64'h0);
    tick();
    check("s1_e1_rv", {63'h0, rv1}, 64'h0);
    seq1("s1");

    // Reseed with zero while running; must match the seed-1 stream.
    seed1 = 64'h0; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    check("s0_e0_rv", {63'h0, rv1}, 64'h0);
    check("s0_e0_rnd", {63'h0, rnd1}, 64'h0);
    tick();
    check("s0_e1_rv", {63'h0, rv1}, 64'h0);
    seq1("s0");

    // Byte-wide instance, default warm-up, en pattern 1,0,1.
    seed8 = 64'h0123_4567_89AB_CDEF; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    check("w8_e0_rv", {63'h0, rv8}, 64'h0);
    check("w8_e0_rnd", {56'h0, rnd8}, 64'h0);
    repeat (63) tick();
    check("w8_e63_rv", {63'h0, rv8}, 64'h0);
    tick();
    check("w8_e64_rv", {63'h0, rv8}, 64'h0);
    m_s = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 64; i++) model_bits(8, bw);
    model_bits(8, b1);
    model_bits(8, b2);
    en8 = 1'b1;
    tick();
    check("en1_rv", {63'h0, rv8}, 64'h1);
    check("en1_rnd", {56'h0, rnd8}, b1);
    en8 = 1'b0;
    tick();
    check("en0_rv", {63'h0, rv8}, 64'h0);
    check("en0_rnd", {56'h0, rnd8}, b1);
    en8 = 1'b1;
    tick();
    check("en1b_rv", {63'h0, rv8}, 64'h1);
    check("en1b_rnd", {56'h0, rnd8}, b2);

    // Reseed in RUN with en held high.
    seed8 = 64'hFEDC_BA98_7654_3210; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    check("rs_e0_rnd", {56'h0, rnd8}, 64'h0);
    n = 0;
    while (rv8 === 1'b0 && n < 200) begin
      n++;
      tick();
    end
    check("rs_gap", 64'(n), 64'd65);
    m_s = 64'hFEDC_BA98_7654_3210;
    for (int i = 0; i < 64; i++) model_bits(8, bw);
    for (int i = 0; i < 3; i++) begin
      model_bits(8, bw);
      check("rs_rv", {63'h0, rv8}, 64'h1);
      check("rs_rnd", {56'h0, rnd8}, bw);
      tick();
    end

    // Asynchronous reset in the middle of a RUN cycle.
    check("pre_rst_rv8", {63'h0, rv8}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_rv8", {63'h0, rv8}, 64'h0);
    check("arst_rnd8", {56'h0, rnd8}, 64'h0);
    check("arst_sr8", {63'h0, sr8}, 64'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_rst_out", {46'h0, rnd8, rnd1, rv8, rv1}, 64'h0);
    end

    // Seed offered in the very first cycle after release must be taken.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) begin
      rst = 1'b0; seed1 = 64'h1; sv1 = 1'b1;
    end
    tick();
    sv1 = 1'b0;
    check("fst_e0_rv", {63'h0, rv1}, 64'h0);
    tick();
    check("fst_e1_rv", {63'h0, rv1}, 64'h0);
    seq1("fst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
